fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port scheduler that shares the write side of one `synchronus_fifo` instance among `N_REQ` producers. Each producer uses a valid/ready handshake. The block grants bounded bursts and never writes into a full FIFO, so the FIFO never raises `overflow`. At burst boundaries it inserts one-cycle write gaps so the consumer's reads are not starved: the FIFO gives `wr_en` priority over `rd_en`.

## Interface
- `N_REQ`, 4: number of producers, 2..16.
- `WIDTH`, 8: data width; must equal the FIFO `WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `N_REQ`: producer i has a beat.
- `req_data`, in, `N_REQ*WIDTH`: producer i's data is in bits `[i*WIDTH +: WIDTH]`.
- `req_ready`, out, `N_REQ`: beat of producer i is accepted this cycle.
- `fifo_full`, in, 1: FIFO `full` flag.
- `rd_req`, in, 1: consumer wants to read; requests a write gap.
- `fifo_wr_en`, out, 1: drives FIFO `wr_en`.
- `fifo_wdata`, out, `WIDTH`: drives FIFO `wdata`.
- `grant_id`, out, `$clog2(N_REQ)`: producer currently or last granted.
- `busy`, out, 1: high when the state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, GAP.
- **IDLE**
  - If any `req_valid` is set: load `grant_id` with the first set index searching upward from `last+1` mod `N_REQ`, where `last` is the previously granted index.
  - Clear `beat_cnt` and go to GRANT.
  - If no `req_valid` is set, stay in IDLE.
- **GRANT**
  - `fifo_wr_en = req_valid[grant_id] & ~fifo_full`.
  - `req_ready[grant_id] = fifo_wr_en`; all other `req_ready` bits are 0.
  - `fifo_wdata = req_data` slice of `grant_id`, presented every cycle.
  - On each accepted beat, `beat_cnt` increments. `beat_cnt` is `$clog2(MAX_BURST+1)` bits wide.
  - The burst ends on either condition:
    - an accepted beat with `beat_cnt == MAX_BURST-1`;
    - any cycle with `req_valid[grant_id] == 0`. No beat is taken that cycle.
  - At burst end, `last <= grant_id`. Go to GAP if `rd_req == 1`, otherwise to IDLE.
  - `fifo_full` stalls the burst without ending it. `fifo_wr_en` stays 0, which lets FIFO reads proceed, so `full` eventually clears.
- **GAP**
  - `fifo_wr_en = 0`, all `req_ready = 0`.
  - Exactly one cycle, then IDLE.
- Outside GRANT, `fifo_wr_en` and `req_ready` are 0. `fifo_wdata` holds the granted slice and is don't-care for the FIFO.
- Invariant: `fifo_wr_en & fifo_full` is never 1.
- Reset values:
  - state IDLE, `grant_id` 0, `last` `N_REQ-1` (first search starts at index 0), `beat_cnt` 0;
  - `fifo_wr_en` 0, `req_ready` all 0, `busy` 0.
- Reset mid-burst: the FSM returns to IDLE the next edge. Beats already accepted stay in the FIFO; the FIFO is reset separately by its own reset.

## Timing
- Arbitration latency:
  - `req_valid` rising in IDLE at cycle t gives GRANT at t+1.
  - The first write is at the edge ending t+1.
  - The producer samples `req_ready` high in cycle t+1.
- An uninterrupted burst is `MAX_BURST` consecutive beats.
- Minimum gap between bursts:
  - 1 cycle (IDLE) when `rd_req=0`;
  - 2 cycles (GAP + IDLE) when `rd_req=1`.
- `fifo_wr_en`, `req_ready` and `fifo_wdata` are combinational from registered state plus `req_valid`/`fifo_full`/`req_data`. No combinational path exists from `rd_req` to outputs.
- The FIFO `full` flag is combinational from its pointers, so it reflects a write in the cycle after it. The `~fifo_full` gate is evaluated each cycle, so back-to-back writes up to the last free slot are legal.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state encoding constants `ST_IDLE`, `ST_GRANT`, `ST_GAP` (2 bits);
  - a width helper for `grant_id`/`beat_cnt` via `$clog2`.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`[`N_REQ`], `last`.
  - Outputs: `idx`, `any`.
  - Implemented as a double-width rotate-and-priority-encode.
- Top level holds the FSM, `beat_cnt`, `last`, and the data mux.

## Test plan
- Reset, then all `req_valid`=0 for 10 cycles: `busy`=0, `fifo_wr_en`=0 and `req_ready`=0 throughout.
- `N_REQ`=4, `MAX_BURST`=4, all producers continuously valid, `rd_req`=0:
  - grants go 0,1,2,3,0 in order;
  - each grant writes exactly 4 beats, followed by 1 idle cycle;
  - the FIFO read-back order matches the tagged data.
- Producer 2 alone valid for 2 beats, then drops `req_valid`: 2 writes occur, then the FSM returns to IDLE; the next grant search starts at index 3.
- FIFO filled to 15/16 with burst in progress: 1 beat is written, then `fifo_wr_en` stays 0 while `full`=1. The FIFO `overflow` is never set. After one FIFO read, the burst resumes with the next beat.
- `rd_req`=1 held with all producers valid: every burst is followed by GAP then IDLE. The FIFO `rd_en` pulses issued during GAP return data, and `underflow` never sets.
- Assert `reset` during beat 2 of a burst: the next cycle has state IDLE, `fifo_wr_en`=0 and `grant_id`=0. After reset, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared FSM encodings and width helpers for fifo_wr_arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  // Scheduler states; 2-bit encoding kept compatible with legacy consumers
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches upward from
//                last+1 (mod N_REQ) using a double-width rotate followed by
//                a lowest-set-bit priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    idx,
  output logic             any
);

  localparam int SW = IW + 1;

  logic [IW-1:0]      start;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] rot;
  logic [SW-1:0]      off;
  logic [SW-1:0]      sum;

  // Rotate the request vector so bit 0 is the first candidate, then encode
  always_comb begin
    start = (last == IW'(N_REQ - 1)) ? '0 : last + IW'(1);
    dbl   = {req, req};
    rot   = dbl >> start;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
    sum = {1'b0, start} + off;
    idx = (sum >= SW'(N_REQ)) ? IW'(sum - SW'(N_REQ)) : sum[IW-1:0];
    any = |req;
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin write-port scheduler in front of a synchronous
//                FIFO. Grants bounded bursts, never writes into a full FIFO
//                and optionally leaves a one-cycle write gap for readers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  input  logic                       rd_req,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int             IW        = cnt_width(N_REQ);
  localparam int             BW        = cnt_width(MAX_BURST + 1);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(MAX_BURST - 1);

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [BW-1:0] beat_cnt;
  logic          cur_valid;
  logic          burst_end;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req  (req_valid),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Write strobe, ready steering, data mux and burst termination
  always_comb begin
    cur_valid           = req_valid[grant_id];
    fifo_wr_en          = (state == ST_GRANT) && cur_valid && !fifo_full;
    req_ready           = '0;
    req_ready[grant_id] = fifo_wr_en;
    fifo_wdata          = req_data[int'(grant_id) * WIDTH +: WIDTH];
    // A stall on full does not end the burst; only a final beat or a
    // producer dropping valid does
    burst_end           = (state == ST_GRANT) &&
                          ((fifo_wr_en && (beat_cnt == LAST_BEAT)) || !cur_valid);
  end

  assign busy = (state != ST_IDLE);

  // Scheduler FSM with burst counter and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      last     <= IW'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (fifo_wr_en) beat_cnt <= beat_cnt + BW'(1);
          if (burst_end) begin
            last  <= grant_id;
            state <= rd_req ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
